// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder cell reused over WIDTH cycles, LSB first,
// with the carry fed back through a register and a registered result.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int             cw       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [cw-1:0]  last_bit = cw'(WIDTH - 1);

   typedef enum logic [1:0] {
      s_idle,
      s_run,
      s_done
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sa, sb, ps;
   logic             cy;
   logic [cw-1:0]    cnt;
   logic             s, co;
   logic             accept, last;

   full_adder u_fa (
      .a  (sa[0]),
      .b  (sb[0]),
      .ci (cy),
      .s  (s),
      .co (co)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= s_idle;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         s_idle: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = s_run;
            end
         end
         s_run: begin
            if (cnt == last_bit) begin
               last      = 1'b1;
               state_nxt = s_done;
            end
         end
         s_done:  state_nxt = s_idle;
         default: state_nxt = s_idle;
      endcase
   end

   // busy/done are decoded from the next state so they leave as flop outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa   <= '0;
         sb   <= '0;
         ps   <= '0;
         cy   <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nxt != s_idle);
         done <= (state_nxt == s_done);
         if (accept) begin
            sa  <= a;
            sb  <= b;
            cy  <= cin;
            cnt <= '0;
         end else if (state == s_run) begin
            ps  <= {s, ps[WIDTH-1:1]};
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            cy  <= co;
            cnt <= cnt + 1'b1;
            if (last) begin
               sum  <= {s, ps[WIDTH-1:1]};
               cout <= co;
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed corner cases plus
// randomized operations compared against plain a+b+cin arithmetic.

module tb_serial_adder_ctrl;
   localparam int width = 8;

   logic             clk = 1'b0;
   logic             rst, start, cin;
   logic [width-1:0] a, b, sum;
   logic             busy, done, cout;

   int               n_checks = 0;
   int               n_pass   = 0;
   logic [width:0]   last_res = '0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(width)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for done (bounded); the previous result must hold until then.
   task automatic wait_done(input bit scramble, output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 4*width) begin
         check("hold", {23'd0, cout, sum}, {23'd0, last_res});
         if (scramble) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
         end
         tick();
         lat++;
      end
   endtask

   task automatic do_op(input logic [width-1:0] ta, input logic [width-1:0] tb_v,
                        input logic tc, input bit scramble);
      logic [width:0] exp;
      int             lat;
      exp   = {1'b0, ta} + {1'b0, tb_v} + 9'(tc);
      a     = ta;
      b     = tb_v;
      cin   = tc;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("accept_busy", {31'd0, busy}, 32'd1);
      check("accept_done", {31'd0, done}, 32'd0);
      wait_done(scramble, lat);
      check("latency", lat, width);
      check("result", {23'd0, cout, sum}, {23'd0, exp});
      check("done_busy", {31'd0, busy}, 32'd1);
      last_res = exp;
      tick();
      check("done_pulse", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("result_hold", {23'd0, cout, sum}, {23'd0, exp});
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit seen;
      logic [width-1:0] corner [4];
      corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h80; corner[3] = 8'hFF;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      check("rst_sum",  {24'd0, sum},  32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      tick();

      do_op(8'h00, 8'h00, 1'b0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0);
      do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
      do_op(8'h5A, 8'h35, 1'b1, 1'b1);

      // start pulsed mid-RUN and held from DONE back into IDLE
      a = 8'h5A; b = 8'h35; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 4*width) begin tick(); lat++; end
      check("busy_start_latency", lat + 3, width);
      check("busy_start_result", {23'd0, cout, sum}, 32'h090);
      last_res = 9'h090;
      a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
      tick();
      check("done_start_ignored_busy", {31'd0, busy}, 32'd0);
      check("done_start_ignored_done", {31'd0, done}, 32'd0);
      tick();
      start = 1'b0;
      check("held_start_accept", {31'd0, busy}, 32'd1);
      wait_done(1'b0, lat);
      check("held_start_latency", lat, width);
      check("held_start_result", {23'd0, cout, sum}, 32'h003);
      last_res = 9'h003;
      tick();
      check("held_start_idle", {31'd0, busy}, 32'd0);

      // asynchronous reset in RUN cycle 5
      a = 8'h37; b = 8'h44; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_sum",  {24'd0, sum},  32'd0);
      check("midrst_cout", {31'd0, cout}, 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      last_res = '0;
      seen = 1'b0;
      repeat (12) begin
         tick();
         if (done) seen = 1'b1;
      end
      check("no_done_after_rst", {31'd0, seen}, 32'd0);
      do_op(8'h01, 8'h01, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            for (int k = 0; k < 2; k++)
               do_op(corner[i], corner[j], 1'(k), 1'b0);

      for (int i = 0; i < 1500; i++)
         do_op(8'($urandom), 8'($urandom), 1'($urandom), (i % 4) == 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
